// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: forwarding select codes and scoreboard entry type.
// Entry rd field is sized for the widest supported register file (REG_W <= 8).
package hazard_scoreboard_pkg;
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;
    localparam int RD_W = 8;
    typedef struct packed {
        logic            v;
        logic [RD_W-1:0] rd;
        logic            wr;
        logic            ld;
    } sb_entry_t;
endpackage

// File: rtl/sb_src_match.sv
// sb_src_match: youngest in-flight writer of one source operand.
module sb_src_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W = 3,
    parameter int DEPTH = 4
) (
    input  logic [REG_W-1:0]               addr_i,
    input  logic                           used_i,
    input  sb_entry_t [DEPTH-1:0]          entries_i,
    output logic [$clog2(DEPTH)-1:0]       idx_o,
    output logic                           found_o,
    output logic                           ld_o
);
    localparam int IW = $clog2(DEPTH);
    // Scan oldest to youngest so the youngest match overwrites the rest.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        ld_o    = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (used_i && entries_i[i].v && entries_i[i].wr && entries_i[i].rd == RD_W'(addr_i)) begin
                idx_o   = IW'(i);
                found_o = 1'b1;
                ld_o    = entries_i[i].ld;
            end
        end
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-side destination scoreboard producing stall, bubble,
// flush and forwarding controls, with saturating stall/flush event counters.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W     = 3,
    parameter int DEPTH     = 4,
    parameter int FLUSH_CYC = 1,
    parameter int FWD_EN    = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [REG_W-1:0] rs_addr,
    input  logic             rs_used,
    input  logic [REG_W-1:0] rt_addr,
    input  logic             rt_used,
    input  logic [REG_W-1:0] rd_addr,
    input  logic             rd_write,
    input  logic             is_load,
    input  logic             ctrl_xfer,
    output logic             stall,
    output logic             insert_nop,
    output logic [1:0]       fwd_rs_sel,
    output logic [1:0]       fwd_rt_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int IW = $clog2(DEPTH);
    sb_entry_t [DEPTH-1:0] sb_q, sb_d;
    logic [2:0]       flush_q, flush_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic [IW-1:0]    rs_idx, rt_idx;
    logic             rs_hit, rt_hit, rs_ld, rt_ld, rs_haz, rt_haz, flushing, accept;

    sb_src_match #(.REG_W(REG_W), .DEPTH(DEPTH)) u_rs (
        .addr_i(rs_addr), .used_i(rs_used), .entries_i(sb_q),
        .idx_o(rs_idx), .found_o(rs_hit), .ld_o(rs_ld)
    );
    sb_src_match #(.REG_W(REG_W), .DEPTH(DEPTH)) u_rt (
        .addr_i(rt_addr), .used_i(rt_used), .entries_i(sb_q),
        .idx_o(rt_idx), .found_o(rt_hit), .ld_o(rt_ld)
    );

    // With forwarding only a load still in EX blocks; without it any writer not yet past WB does.
    always_comb begin
        flushing    = flush_q != 3'd0;
        rs_haz      = FWD_EN != 0 ? rs_hit && rs_idx == '0 && rs_ld : rs_hit && rs_idx <= IW'(DEPTH - 2);
        rt_haz      = FWD_EN != 0 ? rt_hit && rt_idx == '0 && rt_ld : rt_hit && rt_idx <= IW'(DEPTH - 2);
        fwd_rs_sel  = (FWD_EN != 0 && rs_hit && rs_idx <= IW'(2) && !(rs_idx == '0 && rs_ld)) ? 2'(rs_idx) + FWD_EX : FWD_RF;
        fwd_rt_sel  = (FWD_EN != 0 && rt_hit && rt_idx <= IW'(2) && !(rt_idx == '0 && rt_ld)) ? 2'(rt_idx) + FWD_EX : FWD_RF;
        stall       = (rs_haz || rt_haz) && issue_valid && !flushing;
        insert_nop  = stall || flushing;
        accept      = issue_valid && !stall && !flushing;
        sb_d        = {sb_q[DEPTH-2:0], accept ? sb_entry_t'{v: 1'b1, rd: RD_W'(rd_addr), wr: rd_write, ld: is_load} : sb_entry_t'('0)};
        flush_d     = (accept && ctrl_xfer) ? 3'(FLUSH_CYC) : flush_q - 3'(flushing);
        stall_cnt_d = stall_cnt_q + CNT_W'(stall && !(&stall_cnt_q));
        flush_cnt_d = flush_cnt_q + CNT_W'(flushing && !(&flush_cnt_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q        <= '0;
            flush_q     <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            flush_q     <= flush_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of forwarding, interlocks, flush and counters
// on a forwarding build (dut0) and an interlock-only build (dut1).
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst, issue_valid, rs_used, rt_used, rd_write, is_load, ctrl_xfer;
    logic [2:0] rs_addr, rt_addr, rd_addr;
    logic stall0, nop0, stall1, nop1;
    logic [1:0] rs0, rt0, rs1, rt1;
    logic [3:0] sc0, fc0;
    logic [15:0] sc1, fc1;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_W(3), .DEPTH(4), .FLUSH_CYC(2), .FWD_EN(1), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .rs_addr(rs_addr), .rs_used(rs_used),
        .rt_addr(rt_addr), .rt_used(rt_used), .rd_addr(rd_addr), .rd_write(rd_write),
        .is_load(is_load), .ctrl_xfer(ctrl_xfer), .stall(stall0), .insert_nop(nop0),
        .fwd_rs_sel(rs0), .fwd_rt_sel(rt0), .stall_cnt(sc0), .flush_cnt(fc0)
    );
    hazard_scoreboard #(.REG_W(3), .DEPTH(4), .FLUSH_CYC(2), .FWD_EN(0), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .rs_addr(rs_addr), .rs_used(rs_used),
        .rt_addr(rt_addr), .rt_used(rt_used), .rd_addr(rd_addr), .rd_write(rd_write),
        .is_load(is_load), .ctrl_xfer(ctrl_xfer), .stall(stall1), .insert_nop(nop1),
        .fwd_rs_sel(rs1), .fwd_rt_sel(rt1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    // Drives one decode slot for one cycle; outputs are settled 1 time unit later.
    task automatic drive(input logic v, input logic [2:0] rs, input logic rsu, input logic [2:0] rt,
                         input logic rtu, input logic [2:0] rd, input logic wr, input logic ld, input logic cx);
        @(negedge clk);
        issue_valid = v; rs_addr = rs; rs_used = rsu; rt_addr = rt; rt_used = rtu;
        rd_addr = rd; rd_write = wr; is_load = ld; ctrl_xfer = cx;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 3, 1, 3, 1, 3, 1, 1, 1);
        drive(1, 3, 1, 3, 1, 3, 1, 1, 1);
        rst = 1'b0;
        tests++; if (stall0 !== 1'b0) begin fails++; $display("FAIL rst_stall0 got %b want 0", stall0); end
        tests++; if (nop0 !== 1'b0) begin fails++; $display("FAIL rst_nop0 got %b want 0", nop0); end
        tests++; if ({rs0, rt0} !== 4'b0) begin fails++; $display("FAIL rst_sel0 got %b want 0000", {rs0, rt0}); end
        tests++; if ({sc0, fc0} !== 8'b0) begin fails++; $display("FAIL rst_cnt0 got %h want 00", {sc0, fc0}); end
        tests++; if ({stall1, nop1, rs1, rt1} !== 6'b0) begin fails++; $display("FAIL rst_out1 got %b want 000000", {stall1, nop1, rs1, rt1}); end
    endtask

    task automatic test_forward();
        logic [1:0] exp_sel [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
            tests++; if (rs0 !== exp_sel[k] || stall0 !== 1'b0) begin
                fails++; $display("FAIL fwd_rs_%0d got sel=%0d stall=%b want sel=%0d stall=0", k, rs0, stall0, exp_sel[k]);
            end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 0, 0, 0, 2, 1, 1, 0);
        drive(1, 0, 0, 2, 1, 0, 0, 0, 0);
        tests++; if (stall0 !== 1'b1 || nop0 !== 1'b1) begin fails++; $display("FAIL lu_stall got stall=%b nop=%b want 1 1", stall0, nop0); end
        drive(1, 0, 0, 2, 1, 0, 0, 0, 0);
        tests++; if (stall0 !== 1'b0 || rt0 !== 2'd2) begin fails++; $display("FAIL lu_release got stall=%b sel=%0d want 0 2", stall0, rt0); end
        tests++; if (sc0 !== 4'd1) begin fails++; $display("FAIL lu_cnt got %0d want 1", sc0); end
    endtask

    task automatic test_no_fwd();
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
            tests++; if (stall1 !== 1'b1) begin fails++; $display("FAIL nf_stall_%0d got %b want 1", k, stall1); end
        end
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
        tests++; if (stall1 !== 1'b0 || rs1 !== 2'd0) begin fails++; $display("FAIL nf_release got stall=%b sel=%0d want 0 0", stall1, rs1); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tests++; if (sc1 !== 16'd3) begin fails++; $display("FAIL nf_cnt got %0d want 3", sc1); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 0, 0, 0, 0, 4, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        tests++; if (stall1 !== 1'b0 || nop1 !== 1'b0) begin fails++; $display("FAIL fl_jump got stall=%b nop=%b want 0 0", stall1, nop1); end
        for (int k = 0; k < 2; k++) begin
            drive(1, 4, 1, 0, 0, 0, 0, 0, 0);
            tests++; if (stall1 !== 1'b0 || nop1 !== 1'b1) begin fails++; $display("FAIL fl_window_%0d got stall=%b nop=%b want 0 1", k, stall1, nop1); end
        end
        drive(1, 4, 1, 0, 0, 0, 0, 0, 0);
        tests++; if (stall1 !== 1'b0 || nop1 !== 1'b0) begin fails++; $display("FAIL fl_end got stall=%b nop=%b want 0 0", stall1, nop1); end
        tests++; if (fc1 !== 16'd2) begin fails++; $display("FAIL fl_cnt got %0d want 2", fc1); end
    endtask

    task automatic test_jump_load_reset();
        do_reset();
        drive(1, 0, 0, 0, 0, 2, 1, 1, 0);
        drive(1, 2, 1, 0, 0, 0, 0, 0, 1);
        tests++; if (stall0 !== 1'b1 || nop0 !== 1'b1) begin fails++; $display("FAIL jl_stall got stall=%b nop=%b want 1 1", stall0, nop0); end
        drive(1, 2, 1, 0, 0, 0, 0, 0, 1);
        tests++; if (stall0 !== 1'b0 || nop0 !== 1'b0 || rs0 !== 2'd2) begin
            fails++; $display("FAIL jl_accept got stall=%b nop=%b sel=%0d want 0 0 2", stall0, nop0, rs0);
        end
        drive(1, 2, 1, 0, 0, 0, 0, 0, 0);
        tests++; if (stall0 !== 1'b0 || nop0 !== 1'b1) begin fails++; $display("FAIL jl_flush got stall=%b nop=%b want 0 1", stall0, nop0); end
        rst = 1'b1;
        drive(1, 2, 1, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tests++; if (stall0 !== 1'b0 || nop0 !== 1'b0 || sc0 !== 4'd0 || fc0 !== 4'd0) begin
            fails++; $display("FAIL jl_reset got stall=%b nop=%b sc=%0d fc=%0d want 0 0 0 0", stall0, nop0, sc0, fc0);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 0; k < 19; k++) begin
            drive(1, 0, 0, 0, 0, 1, 1, 1, 0);
            drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
            drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tests++; if (sc0 !== 4'hF) begin fails++; $display("FAIL sat_cnt got %0d want 15", sc0); end
    endtask

    initial begin
        rst = 1'b1;
        {issue_valid, rs_used, rt_used, rd_write, is_load, ctrl_xfer} = '0;
        {rs_addr, rt_addr, rd_addr} = '0;
        test_reset();
        test_forward();
        test_load_use();
        test_no_fwd();
        test_flush();
        test_jump_load_reset();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the decode-stage hazard detector: a per-stage destination scoreboard for an in-order pipeline with configurable depth and register-file size.
- Sits beside decode. Compares the current instruction's sources against in-flight destinations and produces stall, bubble and flush controls plus per-operand forwarding selects.
- Adds behaviour the earlier unit lacks: a real load-use interlock, a configurable control-transfer flush window, a forwarding enable switch, and saturating event counters.

Parameters:
- REG_W, 3, register address width (2**REG_W architectural registers).
- DEPTH, 4, tracked stages after decode: entry 0 = EX, 1 = MEM, 2 = WB, further entries are extra stages; minimum 3.
- FLUSH_CYC, 1, bubbles inserted after an accepted control transfer; 0 disables flushing; maximum 7.
- FWD_EN, 1, 1 = forwarding network present, 0 = interlock only.
- CNT_W, 16, width of the event counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  decode holds a real instruction; 0 for a NOP or empty slot
- rs_addr  in  REG_W  source 1 address
- rs_used  in  1  source 1 is read
- rt_addr  in  REG_W  source 2 address
- rt_used  in  1  source 2 is read
- rd_addr  in  REG_W  destination address
- rd_write  in  1  instruction writes rd
- is_load  in  1  result is available only at the end of MEM
- ctrl_xfer  in  1  instruction is a jump or taken branch
- stall  out  1  hold PC and the IF/ID register
- insert_nop  out  1  inject a bubble into ID/EX
- fwd_rs_sel  out  2  0 = register file, 1 = from EX, 2 = from MEM, 3 = from WB
- fwd_rt_sel  out  2  same encoding as fwd_rs_sel
- stall_cnt  out  CNT_W  cycles with stall=1
- flush_cnt  out  CNT_W  cycles with flush bubbles

Behaviour:
- Scoreboard: DEPTH entries {v, rd, wr, ld}. Every cycle entry i+1 takes entry i and the last entry drops out.
- Entry 0 loads {1, rd_addr, rd_write, is_load} only when the instruction is accepted (issue_valid & ~stall & ~flushing). Otherwise entry 0 loads a bubble with v=0.
- match(i, s): v_i & wr_i & (rd_i == s) & s_used. Register 0 gets no special treatment. The youngest (lowest i) match wins.
- FWD_EN=1:
  - youngest match at i=0 with ld=1 -> stall (load-use).
  - i=0 with ld=0 -> sel 1; i=1 -> sel 2; i=2 -> sel 3.
  - i>=3, or no match -> sel 0. The register file writes before it reads.
- FWD_EN=0: a match at any i <= DEPTH-2 -> stall. Selects are forced to 0.
- stall and insert_nop are combinational, zero latency.
  - stall = hazard & issue_valid & ~flushing.
  - insert_nop = stall | flushing.
- Flush:
  - A 3-bit flush_ctr is loaded with FLUSH_CYC at the clock edge on which a ctrl_xfer instruction is accepted.
  - flushing = (flush_ctr != 0). While flushing: the decode instruction is squashed, hazards are ignored, stall=0, and flush_ctr decrements.
  - ctrl_xfer on a squashed or stalled instruction is ignored. A stalled ctrl_xfer is accepted later, once its hazard clears.
- Counters: stall_cnt increments on stall, flush_cnt increments on flushing. Both saturate at all-ones and never wrap.
- Simultaneous events: a hazard arriving while flushing is ignored, since the instruction is squashed. A ctrl_xfer that also has a hazard stalls first, then starts its flush on acceptance.
- Reset: all entries v=0, flush_ctr=0, counters=0. Outputs after reset: stall=0, insert_nop=0, selects=0. Reset mid-flush or mid-stall aborts immediately; the next cycle is clean.

Decomposition:
- Shared package holds:
  - FWD_RF=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3 select constants;
  - the scoreboard entry typedef {v, rd, wr, ld}.
- One sub-module, sb_src_match: takes one source address plus used flag and the entry vector, and returns the youngest-match index, found flag and load-hit flag. It is instantiated twice, once for rs and once for rt.

Test Plan:
- Write r3 (add), then a dependent read of r3 next cycle -> fwd_rs_sel=1, stall=0. Two cycles later -> sel=2. Three cycles later -> sel=3. Four cycles later -> sel=0.
- Load r2, then an immediately dependent rt=r2 -> stall=1 and insert_nop=1 for exactly 1 cycle, then fwd_rt_sel=2, stall_cnt=1.
- FWD_EN=0, write r5, then read r5 -> stall for DEPTH-1=3 cycles, then sel=0 and the instruction is accepted.
- FLUSH_CYC=2, jump accepted -> insert_nop=1 for the next 2 cycles with stall=0. A hazardous instruction fetched during the window causes no stall. flush_cnt=2.
- Jump whose rs hits a load in EX -> 1 stall cycle, then accept, then FLUSH_CYC bubbles. Assert rst mid-window -> outputs 0 next cycle and counters cleared.
- Force stall for 2**CNT_W+3 cycles (CNT_W=4 build) -> stall_cnt holds at 15.
